// File: rtl/pixel_arbiter.sv
// rtl/pixel_arbiter.sv - two-port round-robin pixel request arbiter feeding a single pixel writer
//
// Purpose:
//   Arbitrates pixel write requests from the CPU (p0) and the fill engine (p1)
//   onto one pixel writer. Nothing is accepted until the video memory clear has
//   finished. Requests whose y coordinate is off-screen are retired at once and
//   counted instead of being written.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   clear_screen_done   video memory clear finished
//   pN_valid/rgb/x/y    request from port N (0 = CPU, 1 = fill engine)
//   pN_ready            combinational accept strobe for port N
//   pN_done             one-cycle pulse when port N's request retires
//   pixel_en            write request to the pixel writer
//   pixel_rgb/x/y       held pixel being written
//   pixel_wr_done       writer completion, one rising edge per write
//   busy                high while waiting for clear or writing a pixel
//   drop_count          saturating count of off-screen requests

module pixel_arbiter #(
  parameter int MAX_Y = 192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_screen_done,
  input  logic       p0_valid,
  input  logic [7:0] p0_rgb,
  input  logic [7:0] p0_x,
  input  logic [7:0] p0_y,
  output logic       p0_ready,
  output logic       p0_done,
  input  logic       p1_valid,
  input  logic [7:0] p1_rgb,
  input  logic [7:0] p1_x,
  input  logic [7:0] p1_y,
  output logic       p1_ready,
  output logic       p1_done,
  output logic       pixel_en,
  output logic [7:0] pixel_rgb,
  output logic [7:0] pixel_x,
  output logic [7:0] pixel_y,
  input  logic       pixel_wr_done,
  output logic       busy,
  output logic [7:0] drop_count
);

  typedef enum logic [1:0] {
    WAIT_CLEAR = 2'd0,
    IDLE       = 2'd1,
    ISSUE      = 2'd2
  } state_t;

  // Widened so MAX_Y above 255 simply makes every 8-bit y legal.
  localparam logic [31:0] MAX_Y_W = 32'(MAX_Y);

  state_t     state;
  logic       favour_p1;  // round-robin pointer: port preferred on a tie
  logic       owner;      // port that owns the held request
  logic       done_q;     // previous pixel_wr_done, for edge detection
  logic [7:0] hold_rgb;
  logic [7:0] hold_x;
  logic [7:0] hold_y;

  logic       grant_p1;
  logic       accept;
  logic [7:0] acc_rgb;
  logic [7:0] acc_x;
  logic [7:0] acc_y;
  logic       acc_drop;
  logic       completion;

  // p1 wins when it is the only requester, or on a tie when it is favoured.
  assign grant_p1 = p1_valid & (~p0_valid | favour_p1);

  assign p0_ready = (state == IDLE) & p0_valid & ~grant_p1;
  assign p1_ready = (state == IDLE) & p1_valid &  grant_p1;
  assign accept   = p0_ready | p1_ready;

  assign acc_rgb  = grant_p1 ? p1_rgb : p0_rgb;
  assign acc_x    = grant_p1 ? p1_x   : p0_x;
  assign acc_y    = grant_p1 ? p1_y   : p0_y;
  assign acc_drop = ({24'd0, acc_y} >= MAX_Y_W);

  // Gating pixel_en with pixel_wr_done keeps a still-high done from the
  // previous write from being read by the writer as a fresh request.
  assign pixel_en   = (state == ISSUE) & ~pixel_wr_done;
  assign completion = (state == ISSUE) & pixel_wr_done & ~done_q;

  assign pixel_rgb = hold_rgb;
  assign pixel_x   = hold_x;
  assign pixel_y   = hold_y;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_CLEAR;
      favour_p1  <= 1'b0;
      owner      <= 1'b0;
      done_q     <= 1'b0;
      hold_rgb   <= 8'd0;
      hold_x     <= 8'd0;
      hold_y     <= 8'd0;
      drop_count <= 8'd0;
      p0_done    <= 1'b0;
      p1_done    <= 1'b0;
    end else begin
      done_q  <= pixel_wr_done;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        WAIT_CLEAR: begin
          if (clear_screen_done) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (accept) begin
            hold_rgb  <= acc_rgb;
            hold_x    <= acc_x;
            hold_y    <= acc_y;
            owner     <= grant_p1;
            favour_p1 <= ~grant_p1;
            if (acc_drop) begin
              // Off-screen: retire immediately, never reaches the writer.
              p0_done <= ~grant_p1;
              p1_done <=  grant_p1;
              if (drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
              end
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (completion) begin
            state   <= IDLE;
            p0_done <= ~owner;
            p1_done <=  owner;
          end
        end
        default: begin
          state <= WAIT_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_arbiter.sv
// tb/tb_pixel_arbiter.sv - self-checking bench for pixel_arbiter with a transaction-level reference model

module tb_pixel_arbiter;

  localparam int MAX_Y = 192;

  logic       clk = 1'b0;
  logic       rst, csd, v0, v1, wd;
  logic [7:0] rgb0, x0, y0, rgb1, x1, y1;
  logic       r0, r1, d0, d1, pen, busy;
  logic [7:0] prgb, px, py, dcnt;

  always #5 clk = ~clk;

  pixel_arbiter #(.MAX_Y(MAX_Y)) dut (
    .clk(clk), .rst(rst), .clear_screen_done(csd),
    .p0_valid(v0), .p0_rgb(rgb0), .p0_x(x0), .p0_y(y0), .p0_ready(r0), .p0_done(d0),
    .p1_valid(v1), .p1_rgb(rgb1), .p1_x(x1), .p1_y(y1), .p1_ready(r1), .p1_done(d1),
    .pixel_en(pen), .pixel_rgb(prgb), .pixel_x(px), .pixel_y(py),
    .pixel_wr_done(wd), .busy(busy), .drop_count(dcnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model: "cleared" = memory clear seen, "inflight" = a held pixel
  // waiting for the writer, "last" = port granted most recently.
  bit         m_cleared, m_inflight, m_owner, m_last, m_prevwd;
  bit         m_done [2];
  int         m_drop;
  int         starve [2];
  logic [7:0] m_rgb, m_x, m_y;

  // Snapshot of DUT outputs from the most recent tick.
  logic       s_r0, s_r1, s_d0, s_d1, s_pen, s_busy;
  logic [7:0] s_rgb, s_x, s_y, s_drop;
  int         acc_port;

  task automatic model_reset();
    m_cleared = 0; m_inflight = 0; m_owner = 0; m_last = 1; m_prevwd = 0;
    m_done[0] = 0; m_done[1] = 0; m_drop = 0;
    m_rgb = 0; m_x = 0; m_y = 0;
    starve[0] = 0; starve[1] = 0;
  endtask

  // Inputs are set at the falling edge; compare #1 later, advance the model
  // across the next rising edge, and return at the following falling edge.
  task automatic tick();
    int  g;
    bit  idle, e_r0, e_r1, e_pen;
    #1;
    if (v0 && !v1)      g = 0;
    else if (v1 && !v0) g = 1;
    else if (v0 && v1)  g = m_last ? 0 : 1;
    else                g = -1;
    idle  = m_cleared && !m_inflight;
    e_r0  = idle && (g == 0);
    e_r1  = idle && (g == 1);
    e_pen = m_inflight && !wd;

    chk("p0_ready", int'(r0), int'(e_r0));
    chk("p1_ready", int'(r1), int'(e_r1));
    chk("p0_done", int'(d0), int'(m_done[0]));
    chk("p1_done", int'(d1), int'(m_done[1]));
    chk("pixel_en", int'(pen), int'(e_pen));
    chk("busy", int'(busy), int'(!idle));
    chk("pixel_rgb", int'(prgb), int'(m_rgb));
    chk("pixel_x", int'(px), int'(m_x));
    chk("pixel_y", int'(py), int'(m_y));
    chk("drop_count", int'(dcnt), m_drop);

    s_r0 = r0; s_r1 = r1; s_d0 = d0; s_d1 = d1; s_pen = pen; s_busy = busy;
    s_rgb = prgb; s_x = px; s_y = py; s_drop = dcnt;
    acc_port = e_r0 ? 0 : (e_r1 ? 1 : -1);

    if (rst) begin
      model_reset();
    end else begin
      m_done[0] = 0; m_done[1] = 0;
      if (!m_cleared) begin
        if (csd) m_cleared = 1;
      end else if (!m_inflight) begin
        if (acc_port >= 0) begin
          int other = 1 - acc_port;
          if ((other == 0 && v0) || (other == 1 && v1)) begin
            starve[other]++;
            chk("starvation_bound", int'(starve[other] < 2), 1);
          end
          starve[acc_port] = 0;
          m_rgb   = acc_port ? rgb1 : rgb0;
          m_x     = acc_port ? x1   : x0;
          m_y     = acc_port ? y1   : y0;
          m_owner = acc_port[0];
          m_last  = acc_port[0];
          if (int'(m_y) >= MAX_Y) begin
            m_done[acc_port] = 1;
            if (m_drop < 255) m_drop++;
          end else begin
            m_inflight = 1;
          end
        end
      end else if (wd && !m_prevwd) begin
        m_done[m_owner] = 1;
        m_inflight = 0;
      end
      m_prevwd = wd;
    end
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_y();
    return ($urandom_range(0, 7) == 0) ? 8'($urandom_range(MAX_Y, 255)) : 8'($urandom_range(0, MAX_Y - 1));
  endfunction

  int grants [4];
  int ngr;

  initial begin
    rst = 1; csd = 0; v0 = 0; v1 = 0; wd = 0;
    rgb0 = 0; x0 = 0; y0 = 0; rgb1 = 0; x1 = 0; y1 = 0;
    model_reset();
    @(negedge clk);
    tick();
    chk("reset_busy", int'(s_busy), 1);
    chk("reset_pixel_en", int'(s_pen), 0);
    chk("reset_drop", int'(s_drop), 0);

    // Held request while the clear is still running.
    rst = 0; v0 = 1; rgb0 = 8'hE0; x0 = 5; y0 = 10;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait_clear_ready", int'(s_r0), 0);
      chk("wait_clear_pen", int'(s_pen), 0);
    end
    csd = 1;
    tick();
    chk("ready_in_clear_cycle", int'(s_r0), 0);
    tick();
    chk("ready_after_clear", int'(s_r0), 1);
    v0 = 0;

    // Single write: one-cycle latency, writer completes 3 cycles later.
    tick();
    chk("first_pen", int'(s_pen), 1);
    chk("first_rgb", int'(s_rgb), 8'hE0);
    chk("first_x", int'(s_x), 5);
    chk("first_y", int'(s_y), 10);
    tick(); tick();
    wd = 1;
    tick();
    chk("pen_low_on_done", int'(s_pen), 0);
    wd = 0;
    tick();
    chk("p0_done_pulse", int'(s_d0), 1);
    chk("idle_after_done", int'(s_busy), 0);
    tick();
    chk("p0_done_single", int'(s_d0), 0);

    // Both ports continuously valid after a fresh reset.
    rst = 1; tick(); rst = 0; tick();
    v0 = 1; v1 = 1; rgb0 = 8'h11; x0 = 1; y0 = 2; rgb1 = 8'h22; x1 = 3; y1 = 4;
    ngr = 0;
    for (int c = 0; c < 80 && ngr < 4; c++) begin
      wd = m_inflight ? (wd ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b0;
      tick();
      if (s_r0 && v0) begin grants[ngr] = 0; ngr++; end
      else if (s_r1 && v1) begin grants[ngr] = 1; ngr++; end
    end
    chk("rr_grant_count", ngr, 4);
    for (int i = 0; i < 4; i++) chk("rr_grant_order", grants[i], i % 2);
    v0 = 0; v1 = 0;
    for (int c = 0; c < 40 && m_inflight; c++) begin
      wd = wd ? 1'b0 : 1'b1;
      tick();
    end
    chk("rr_drained", int'(m_inflight), 0);
    wd = 0;
    tick();

    // Off-screen requests: drop, pulse, saturate.
    v1 = 1; rgb1 = 8'h01; x1 = 7; y1 = 8'(MAX_Y);
    tick();
    chk("drop_accept", int'(s_r1), 1);
    tick();
    chk("drop_p1_done", int'(s_d1), 1);
    chk("drop_count_one", int'(s_drop), 1);
    chk("drop_no_pen", int'(s_pen), 0);
    for (int i = 0; i < 298; i++) begin
      tick();
      if (s_pen) chk("drop_pen_never", int'(s_pen), 0);
    end
    v1 = 0;
    tick();
    chk("drop_saturated", int'(s_drop), 255);

    // Writer done still high when the pixel is accepted.
    v0 = 1; rgb0 = 8'h3C; x0 = 9; y0 = 100; wd = 1;
    tick();
    chk("stuck_done_accept", int'(s_r0), 1);
    v0 = 0;
    tick();
    chk("stuck_done_pen0", int'(s_pen), 0);
    chk("stuck_done_busy", int'(s_busy), 1);
    tick();
    chk("stuck_done_pen1", int'(s_pen), 0);
    wd = 0;
    tick();
    chk("stuck_done_issue", int'(s_pen), 1);
    chk("stuck_done_nodone", int'(s_d0), 0);
    tick();
    wd = 1;
    tick();
    chk("stuck_done_complete_pen", int'(s_pen), 0);
    tick();
    chk("stuck_done_pulse", int'(s_d0), 1);
    wd = 0;
    tick();
    chk("stuck_done_single", int'(s_d0), 0);

    // Reset in the middle of a write.
    v0 = 1; y0 = 20;
    tick();
    chk("midrst_accept", int'(s_r0), 1);
    v0 = 0;
    tick();
    chk("midrst_pen_before", int'(s_pen), 1);
    rst = 1;
    tick();
    rst = 0; csd = 0;
    tick();
    chk("midrst_pen_after", int'(s_pen), 0);
    chk("midrst_no_done", int'(s_d0), 0);
    chk("midrst_busy", int'(s_busy), 1);
    chk("midrst_drop", int'(s_drop), 0);
    tick();
    chk("midrst_no_late_done", int'(s_d0), 0);

    // Randomized traffic with spurious writer edges and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 599) == 0) rst = 1;
      csd = ($urandom_range(0, 2) != 0);
      if (acc_port == 0) v0 = 0;
      if (acc_port == 1) v1 = 0;
      if (!v0 && $urandom_range(0, 2) == 0) begin
        v0 = 1; rgb0 = 8'($urandom); x0 = 8'($urandom); y0 = rand_y();
      end
      if (!v1 && $urandom_range(0, 2) == 0) begin
        v1 = 1; rgb1 = 8'($urandom); x1 = 8'($urandom); y1 = rand_y();
      end
      if (m_inflight) wd = wd ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      else            wd = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 SHALL have parameter MAX_Y, default 192, first illegal y coordinate (screen height in lines).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- clear_screen_done  in  1  high once video memory clear is complete.
- p0_valid  in  1  CPU pixel request.
- p0_rgb, p0_x, p0_y  in  8 each  CPU pixel colour and coordinates.
- p0_ready  out  1  CPU request accepted this cycle.
- p0_done  out  1  one-cycle pulse when a CPU request retires.
- p1_valid, p1_rgb, p1_x, p1_y, p1_ready, p1_done: as p0, fill-engine port.
- pixel_en  out  1  request to pixel writer.
- pixel_rgb, pixel_x, pixel_y  out  8 each  held pixel to pixel writer.
- pixel_wr_done  in  1  pixel writer completion; rises once per completed write.
- busy  out  1  high when not in IDLE.
- drop_count  out  8  saturating count of out-of-range requests.

Function
REQ-003 SHALL implement states WAIT_CLEAR, IDLE, ISSUE.
REQ-004 SHALL stay in WAIT_CLEAR while clear_screen_done=0; move to IDLE the cycle after it is sampled high.
REQ-005 In IDLE, grant SHALL go to the only valid port; if both valid, to the port not granted last (round-robin pointer, reset value favours p0).
REQ-006 pX_ready SHALL be combinational: high only in IDLE, for the granted port, while pX_valid=1; never both high.
REQ-007 On acceptance (valid&ready), SHALL capture rgb/x/y and owner id into holding registers and update the round-robin pointer.
REQ-008 Accepted request with y >= MAX_Y SHALL be dropped: stay IDLE, pulse owner pX_done next cycle, increment drop_count (saturate at 255, no wrap).
REQ-009 Accepted in-range request SHALL enter ISSUE on the next cycle; latency from acceptance to first pixel_en = 1 cycle.
REQ-010 pixel_rgb/x/y SHALL equal holding registers and stay stable for the whole ISSUE stay.
REQ-011 pixel_en SHALL be combinational: (state==ISSUE) & ~pixel_wr_done, so it is never high while pixel_wr_done=1 (prevents duplicate write).
REQ-012 SHALL register pixel_wr_done into done_q; completion = ISSUE & pixel_wr_done & ~done_q (rising edge).
REQ-013 On completion SHALL pulse owner pX_done for exactly one cycle (the next cycle) and return to IDLE; new acceptance allowed in that IDLE cycle.
REQ-014 Rising edges of pixel_wr_done outside ISSUE SHALL be ignored.
REQ-015 pixel_wr_done held high on entry to ISSUE SHALL keep pixel_en low; issue starts when it falls, completion on next rise.
REQ-016 Valid without ready SHALL be held by the requester; no request SHALL be lost or duplicated.
REQ-017 busy SHALL be high in WAIT_CLEAR and ISSUE.
REQ-018 Holding an unserved port's valid high SHALL be granted within 2 acceptances (starvation bound).

Reset
REQ-019 rst=1 SHALL force WAIT_CLEAR, pointer to p0, done_q=0, drop_count=0, holding registers=0; outputs pixel_en, p0/p1_ready, p0/p1_done=0, busy=1.
REQ-020 Reset mid-ISSUE SHALL drop pixel_en the cycle after the rst edge; in-flight write is abandoned with no pX_done pulse.
REQ-021 rst SHALL dominate every other input in the same cycle.

Verification
REQ-022 clear_screen_done=0, p0_valid=1 for 10 cycles -> p0_ready=0, pixel_en=0 throughout; ready 1 cycle after clear_screen_done=1.
REQ-023 p0 (rgb=0xE0,x=5,y=10) accepted -> next cycle pixel_en=1 with same values; model writer drops done then raises it 3 cycles later -> one p0_done pulse, IDLE.
REQ-024 p0 and p1 valid continuously for 4 requests -> grants p0,p1,p0,p1; no two consecutive grants to one port.
REQ-025 p1 y=192 -> p1_done next cycle, pixel_en never asserted, drop_count=1; 300 such requests -> drop_count=255.
REQ-026 pixel_wr_done=1 at ISSUE entry -> pixel_en=0 until done falls; completion counted only on subsequent rise; no duplicate accept.
REQ-027 rst asserted during ISSUE -> pixel_en=0 next cycle, no pX_done, state WAIT_CLEAR, drop_count=0.
